// File: rtl/vpu_wb_stage_pkg.sv
// Shared VPU definitions: default lane geometry, register-address width and
// the write-back buffer occupancy encoding.
package vpu_wb_stage_pkg;

    localparam int VPU_LANES  = 8;
    localparam int VPU_LANE_W = 16;
    localparam int VPU_RAW    = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/vpu_lane_merge.sv
// Per-lane masked merge: a lane takes the new result where its mask bit is set
// and keeps the old destination contents otherwise.
module vpu_lane_merge
    import vpu_wb_stage_pkg::*;
#(
    parameter int LANES  = VPU_LANES,
    parameter int LANE_W = VPU_LANE_W
) (
    input  logic [LANES*LANE_W-1:0] new_vec,
    input  logic [LANES*LANE_W-1:0] old_vec,
    input  logic [LANES-1:0]        mask,
    output logic [LANES*LANE_W-1:0] merged
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign merged[i*LANE_W +: LANE_W] = mask[i] ? new_vec[i*LANE_W +: LANE_W]
                                                    : old_vec[i*LANE_W +: LANE_W];
    end

endmodule

// File: rtl/vpu_wb_stage.sv
// VPU write-back stage: a 2-entry in-order buffer that drains vector, integer
// and float results into the register files and bypasses the head vector.
module vpu_wb_stage
    import vpu_wb_stage_pkg::*;
#(
    parameter int LANES  = VPU_LANES,
    parameter int LANE_W = VPU_LANE_W,
    parameter int RAW    = VPU_RAW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_vd_we,
    input  logic [RAW-1:0]          in_vd_addr,
    input  logic [LANES*LANE_W-1:0] in_vd,
    input  logic [LANES*LANE_W-1:0] in_vd_old,
    input  logic [LANES-1:0]        in_mask,
    input  logic                    in_rd_we,
    input  logic [RAW-1:0]          in_rd_addr,
    input  logic [31:0]             in_rd,
    input  logic                    in_fd_we,
    input  logic [RAW-1:0]          in_fd_addr,
    input  logic [31:0]             in_fd,
    input  logic                    wb_stall,
    input  logic                    flush,
    output logic                    vrf_we,
    output logic [RAW-1:0]          vrf_waddr,
    output logic [LANES*LANE_W-1:0] vrf_wdata,
    output logic                    xrf_we,
    output logic [RAW-1:0]          xrf_waddr,
    output logic [31:0]             xrf_wdata,
    output logic                    frf_we,
    output logic [RAW-1:0]          frf_waddr,
    output logic [31:0]             frf_wdata,
    output logic                    fwd_vvalid,
    output logic [RAW-1:0]          fwd_vaddr,
    output logic [LANES*LANE_W-1:0] fwd_vdata
);

    localparam int VW = LANES * LANE_W;

    typedef struct packed {
        logic           vwe;
        logic [RAW-1:0] vaddr;
        logic [VW-1:0]  vdata;
        logic           xwe;
        logic [RAW-1:0] xaddr;
        logic [31:0]    xdata;
        logic           fwe;
        logic [RAW-1:0] faddr;
        logic [31:0]    fdata;
    } entry_t;

    occ_e          state_q, state_d;
    entry_t        head_q, head_d;
    entry_t        tail_q, tail_d;
    entry_t        in_entry;
    logic [VW-1:0] merged;
    logic          head_vld;
    logic          accept;
    logic          retire;
    logic          wr_ok;

    vpu_lane_merge #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_merge (
        .new_vec (in_vd),
        .old_vec (in_vd_old),
        .mask    (in_mask),
        .merged  (merged)
    );

    always_comb begin
        in_entry       = '0;
        in_entry.vwe   = in_vd_we;
        in_entry.vaddr = in_vd_addr;
        in_entry.vdata = merged;
        in_entry.xwe   = in_rd_we;
        in_entry.xaddr = in_rd_addr;
        in_entry.xdata = in_rd;
        in_entry.fwe   = in_fd_we;
        in_entry.faddr = in_fd_addr;
        in_entry.fdata = in_fd;
    end

    // Ready comes only from the registered occupancy so wb_stall never reaches it.
    assign in_ready = (state_q != FULL);
    assign head_vld = (state_q != EMPTY);
    assign accept   = in_valid & in_ready & ~flush;
    assign retire   = head_vld & ~wb_stall & ~flush;
    assign wr_ok    = retire & rst_n;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        head_d = in_entry;
                    end else if (accept) begin
                        tail_d  = in_entry;
                        state_d = FULL;
                    end else if (retire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (retire) begin
                        head_d  = tail_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers carry no reset; outputs are gated by occupancy instead.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    assign vrf_we     = wr_ok & head_q.vwe;
    assign xrf_we     = wr_ok & head_q.xwe;
    assign frf_we     = wr_ok & head_q.fwe;
    assign vrf_waddr  = head_vld ? head_q.vaddr : '0;
    assign vrf_wdata  = head_vld ? head_q.vdata : '0;
    assign xrf_waddr  = head_vld ? head_q.xaddr : '0;
    assign xrf_wdata  = head_vld ? head_q.xdata : '0;
    assign frf_waddr  = head_vld ? head_q.faddr : '0;
    assign frf_wdata  = head_vld ? head_q.fdata : '0;
    assign fwd_vvalid = head_vld & head_q.vwe;
    assign fwd_vaddr  = vrf_waddr;
    assign fwd_vdata  = vrf_wdata;

endmodule

// File: doc/vpu_wb_stage.md
VPU_WB_STAGE -- requirements
Module: vpu_wb_stage

Interface
REQ-001 SHALL have parameter LANES, 8, number of 16-bit vector lanes.
REQ-002 SHALL have parameter LANE_W, 16, lane width in bits; vector width VW = LANES*LANE_W (128).
REQ-003 SHALL have parameter RAW, 5, register address width for the vector, integer and float files.
REQ-004 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, synchronous active-low reset.
REQ-005 SHALL have ports: in_valid in 1, VPU result valid; in_ready out 1, stage can accept.
REQ-006 SHALL have ports: in_vd_we in 1, vector write enable; in_vd_addr in RAW, vector destination; in_vd in VW, VPU vector result; in_vd_old in VW, current destination contents; in_mask in LANES, lane write mask.
REQ-007 SHALL have ports: in_rd_we in 1; in_rd_addr in RAW; in_rd in 32, integer/compare result; in_fd_we in 1; in_fd_addr in RAW; in_fd in 32, float scalar result.
REQ-008 SHALL have ports: wb_stall in 1, register-file ports busy this cycle; flush in 1, discard all buffered results.
REQ-009 SHALL have ports: vrf_we out 1; vrf_waddr out RAW; vrf_wdata out VW; xrf_we out 1; xrf_waddr out RAW; xrf_wdata out 32; frf_we out 1; frf_waddr out RAW; frf_wdata out 32.
REQ-010 SHALL have ports: fwd_vvalid out 1; fwd_vaddr out RAW; fwd_vdata out VW; head-entry vector bypass toward operand fetch.

Function
REQ-011 SHALL hold results in a 2-entry in-order buffer; occupancy FSM states EMPTY, ONE, FULL.
REQ-012 SHALL accept an entry on a clock edge where in_valid & in_ready.
REQ-013 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in FULL, from registered state only (no combinational path from wb_stall).
REQ-014 SHALL merge at capture: lane i of the stored vector = in_vd lane i if in_mask[i] else in_vd_old lane i.
REQ-015 SHALL retire the head entry on an edge where occupancy != EMPTY and wb_stall = 0; retired write is visible on *_we in the cycle before that edge.
REQ-016 SHALL assert vrf_we/xrf_we/frf_we = head valid & head's stored enable & !wb_stall; addr/data from head entry.
REQ-017 SHALL give one-cycle latency: entry accepted at edge N appears on write ports during cycle N+1 when buffer was EMPTY.
REQ-018 SHALL handle simultaneous accept and retire: occupancy unchanged, FIFO order kept, ONE->ONE with new entry as head after the old head retires.
REQ-019 SHALL transition: EMPTY->ONE accept; ONE->FULL accept & no retire; ONE->EMPTY retire & no accept; FULL->ONE retire; FULL holds while wb_stall.
REQ-020 SHALL, on flush, go to EMPTY at the next edge, suppress all *_we in the flush cycle, and ignore in_valid in that cycle.
REQ-021 SHALL drive fwd_vvalid = head valid & head vector enable (independent of wb_stall); fwd_vaddr/fwd_vdata = head merged vector.
REQ-022 SHALL retire entries with all three enables 0 as no-ops in one cycle.

Reset
REQ-023 SHALL, when rst_n = 0 at a rising edge, set state EMPTY, in_ready 1, all *_we 0, fwd_vvalid 0, all address/data outputs 0.
REQ-024 SHALL discard a buffered or in-flight entry when reset occurs mid-operation; no write issues on the reset cycle.
REQ-025 SHALL leave buffer data registers without reset requirement beyond REQ-023 output values.

Structure
REQ-026 SHALL take LANES, LANE_W, RAW defaults and the occupancy state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) from the shared VPU package.
REQ-027 SHALL use one sub-module, vpu_lane_merge, performing the combinational per-lane mask merge of REQ-014.

Verification
REQ-028 Reset: rst_n=0 two cycles with in_valid=1 -> in_ready=1, all *_we=0, fwd_vvalid=0 after release.
REQ-029 Masked merge: in_vd=all 16'hAAAA, in_vd_old=all 16'h5555, in_mask=8'b1010_0101, addr 3 -> next cycle vrf_we=1, addr 3, lanes 0,2,5,7=AAAA, others 5555.
REQ-030 Stall fill: wb_stall=1, push A,B -> in_ready=0 after B; third push held; release stall -> A then B written on consecutive cycles, in_ready=1 after A retires.
REQ-031 Simultaneous: ONE state, push C while head retires -> occupancy stays ONE, C written next cycle.
REQ-032 Flush: FULL with stall, assert flush one cycle -> no *_we that cycle, state EMPTY, fwd_vvalid=0 next cycle.
REQ-033 Scalar paths: in_rd_we=1 addr 7 data 32'h0000_00F0, in_fd_we=1 addr 2 data 32'h3F80_0000 -> xrf and frf written same cycle, vrf_we=0.
